// File: rtl/uart_pkg.sv
// Shared types and constants for the BLE command-link UART receiver.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int BAUD_DIV_DFLT = 2604;

    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] CMD_S = 8'h53;
endpackage

// File: rtl/uart_rx_cmd.sv
// 8N1 LSB-first receiver for G/S command bytes: sticky rdy handoff,
// single-cycle framing and overrun pulses.
module uart_rx_cmd
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DFLT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

    logic          sync1;
    logic          rx_s;
    logic          rx_s_q;
    logic [1:0]    warm;
    rx_state_t     state;
    rx_state_t     state_n;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          tick;
    logic          fall;
    logic          ld_half;
    logic          ld_full;
    logic          do_shift;
    logic          stop_ok;
    logic          stop_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_q <= 1'b1;
            warm   <= 2'd0;
        end else begin
            sync1  <= RX;
            rx_s   <= sync1;
            rx_s_q <= rx_s;
            if (warm != 2'd3) warm <= warm + 2'd1;
        end
    end

    // Edges only count once the reset-forced ones have flushed out.
    assign fall = (warm == 2'd3) && rx_s_q && !rx_s;
    assign tick = (state != IDLE) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        ld_half  = 1'b0;
        ld_full  = 1'b0;
        do_shift = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        unique case (state)
            IDLE: if (fall) begin
                ld_half = 1'b1;
                state_n = START;
            end
            START: if (tick) begin
                if (!rx_s) begin
                    ld_full = 1'b1;
                    state_n = DATA;
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: if (tick) begin
                do_shift = 1'b1;
                ld_full  = 1'b1;
                if (bit_cnt == 3'd7) state_n = STOP;
            end
            STOP: if (tick) begin
                stop_ok  = rx_s;
                stop_bad = !rx_s;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            rx_data <= 8'h00;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            if (ld_half)                cnt <= HALF;
            else if (ld_full)           cnt <= FULL;
            else if (state_n == IDLE)   cnt <= '0;
            else                        cnt <= cnt - CW'(1);

            if (state == START)         bit_cnt <= 3'd0;
            else if (do_shift)          bit_cnt <= bit_cnt + 3'd1;

            if (do_shift) shift <= {rx_s, shift[7:1]};

            // A fresh byte wins over a same-cycle acknowledge.
            if (stop_ok) begin
                rx_data <= shift;
                rdy     <= 1'b1;
            end else if (clr_rdy) begin
                rdy     <= 1'b0;
            end
            frm_err <= stop_bad;
            ovr_err <= stop_ok && rdy && !clr_rdy;
        end
    end
endmodule

// File: tb/tb_uart_rx_cmd.sv
// Directed bench for uart_rx_cmd: vector table plus hand-built
// overrun, glitch, break and mid-frame reset sequences.
module tb_uart_rx_cmd;
    import uart_pkg::*;

    localparam int B   = 32;
    localparam int LAT = B / 2 + 9 * B + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RX = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr_err;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   frm_cnt = 0;
    int   ovr_cnt = 0;
    int   rise_cyc = -1;
    logic rdy_q = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       clr;
        logic       exp_rdy;
        logic [7:0] exp_data;
        int         exp_frm;
        int         exp_ovr;
        logic       chk_lat;
    } vec_t;

    vec_t vecs[6];

    uart_rx_cmd #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .ovr_err (ovr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frm_err === 1'b1) frm_cnt++;
        if (ovr_err === 1'b1) ovr_cnt++;
        if (rdy === 1'b1 && rdy_q !== 1'b1) rise_cyc = cyc;
        rdy_q = rdy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_lat(input string name, input int start);
        int d;
        d = rise_cyc - start;
        tests++;
        if (rise_cyc < 0 || d < LAT - 4 || d > LAT + 4) begin
            fails++;
            $display("FAIL %s: latency %0d expected %0d+-4", name, d, LAT);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = stop;
        repeat (B) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
    endtask

    initial begin
        int t;
        int f0;
        int o0;

        vecs[0] = '{CMD_G, 1'b1, 1'b1, 1'b1, CMD_G, 0, 0, 1'b1};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 0, 0, 1'b1};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 0, 0, 1'b1};
        vecs[3] = '{8'h5A, 1'b0, 1'b1, 1'b0, 8'hFF, 1, 0, 1'b0};
        vecs[4] = '{8'h81, 1'b1, 1'b0, 1'b1, 8'h81, 0, 0, 1'b1};
        vecs[5] = '{8'h12, 1'b1, 1'b0, 1'b1, 8'h12, 0, 1, 1'b0};

        repeat (5) @(negedge clk);
        check("rst_data", 32'(rx_data), 32'h0);
        check("rst_rdy", 32'(rdy), 32'h0);
        check("rst_frm", 32'(frm_err), 32'h0);
        check("rst_ovr", 32'(ovr_err), 32'h0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].clr) begin
                pulse_clr();
                check($sformatf("v%0d_clr", v), 32'(rdy), 32'h0);
            end
            f0 = frm_cnt;
            o0 = ovr_cnt;
            rise_cyc = -1;
            t = cyc;
            send(vecs[v].data, vecs[v].stop);
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_rdy", v), 32'(rdy), 32'(vecs[v].exp_rdy));
            check($sformatf("v%0d_data", v), 32'(rx_data),
                  32'(vecs[v].exp_data));
            check($sformatf("v%0d_frm", v), 32'(frm_cnt - f0),
                  32'(vecs[v].exp_frm));
            check($sformatf("v%0d_ovr", v), 32'(ovr_cnt - o0),
                  32'(vecs[v].exp_ovr));
            if (vecs[v].chk_lat) check_lat($sformatf("v%0d_lat", v), t);
        end

        // Back-to-back overrun.
        pulse_clr();
        o0 = ovr_cnt;
        begin
            send(CMD_S, 1'b1);
            send(8'hA5, 1'b1);
        end
        repeat (4) @(negedge clk);
        check("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_data", 32'(rx_data), 32'hA5);
        check("ovr_rdy", 32'(rdy), 32'h1);

        // Acknowledge coincident with the second stop-bit sample.
        pulse_clr();
        o0 = ovr_cnt;
        t = cyc;
        fork
            begin
                send(CMD_S, 1'b1);
                send(8'hA5, 1'b1);
            end
            begin
                while (cyc < t + 10 * B + LAT - 1) @(negedge clk);
                clr_rdy = 1'b1;
                @(negedge clk);
                clr_rdy = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("coin_ovr", 32'(ovr_cnt - o0), 32'd0);
        check("coin_rdy", 32'(rdy), 32'h1);
        check("coin_data", 32'(rx_data), 32'hA5);

        // Short glitch is a false start.
        pulse_clr();
        f0 = frm_cnt;
        RX = 1'b0;
        repeat (5) @(negedge clk);
        RX = 1'b1;
        repeat (B / 2 + 3 + 4) @(negedge clk);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        check("glitch_rdy", 32'(rdy), 32'h0);
        check("glitch_frm", 32'(frm_cnt - f0), 32'd0);
        send(CMD_S, 1'b1);
        repeat (4) @(negedge clk);
        check("glitch_next", 32'(rx_data), 32'(CMD_S));
        check("glitch_next_rdy", 32'(rdy), 32'h1);

        // Framing error followed by a held-low break.
        f0 = frm_cnt;
        o0 = ovr_cnt;
        send(8'h55, 1'b0);
        RX = 1'b0;
        repeat (10 * B) @(negedge clk);
        check("brk_frm", 32'(frm_cnt - f0), 32'd1);
        check("brk_ovr", 32'(ovr_cnt - o0), 32'd0);
        check("brk_rdy", 32'(rdy), 32'h1);
        check("brk_data", 32'(rx_data), 32'(CMD_S));
        check("brk_state", 32'(dut.state), 32'(IDLE));
        RX = 1'b1;
        repeat (B) @(negedge clk);
        pulse_clr();
        f0 = frm_cnt;
        send(CMD_G, 1'b1);
        repeat (4) @(negedge clk);
        check("brk_next", 32'(rx_data), 32'(CMD_G));
        check("brk_next_frm", 32'(frm_cnt - f0), 32'd0);

        // Reset during data bit 4 of 0xC3 (line low there).
        t = cyc;
        fork
            send(8'hC3, 1'b1);
            begin
                while (cyc < t + 5 * B + 4) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check("mid_rst_data", 32'(rx_data), 32'h0);
                check("mid_rst_rdy", 32'(rdy), 32'h0);
                check("mid_rst_state", 32'(dut.state), 32'(IDLE));
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        f0 = frm_cnt;
        repeat (B) @(negedge clk);
        check("mid_after_rdy", 32'(rdy), 32'h0);
        check("mid_after_state", 32'(dut.state), 32'(IDLE));
        rise_cyc = -1;
        t = cyc;
        send(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        check("mid_next_data", 32'(rx_data), 32'h3C);
        check("mid_next_rdy", 32'(rdy), 32'h1);
        check("mid_next_frm", 32'(frm_cnt - f0), 32'd0);
        check_lat("mid_next_lat", t);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
